pattern_count_ctrl: RTL

PATTERN_COUNT_CTRL -- requirements
Module: pattern_count_ctrl

---
 rtl/pattern_count_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/pattern_count_ctrl.sv
// pattern_count_ctrl: counts 5-bit pattern hits in a byte message held in data memory.
// Result bytes ctb, cto and cts are written back after the pattern byte.
module pattern_count_ctrl #(
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int NBYTES = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData
);
  typedef enum logic [3:0] {IDLE, PAT_RD, PAT_LD, BYTE_RD, BYTE_CMP, WR_CTB, WR_CTO, WR_CTS, DONE} state_t;
  state_t state, next;
  logic [4:0] p;
  logic [7:0] ctb, cto, cts, prev, i;
  logic [3:0] in_m, x_m;
  logic [2:0] in_hits, x_hits;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      p <= '0;
      ctb <= '0;
      cto <= '0;
      cts <= '0;
      prev <= '0;
      i <= '0;
    end else if (state == PAT_LD) begin
      p <= MemRdData[7:3];
      ctb <= '0;
      cto <= '0;
      cts <= '0;
      prev <= '0;
      i <= '0;
    end else if (state == BYTE_CMP) begin
      ctb <= ctb + 8'(in_hits);
      cto <= cto + 8'(in_hits != 3'd0);
      cts <= cts + 8'(in_hits) + 8'(x_hits);
      prev <= MemRdData;
      i <= i + 8'd1;
    end

  always_comb begin
    in_m = {MemRdData[7:3] == p, MemRdData[6:2] == p, MemRdData[5:1] == p, MemRdData[4:0] == p};
    // Windows straddling the previous byte; none exist for the first byte.
    x_m = (i == 8'd0) ? 4'b0 : {{prev[3:0], MemRdData[7]} == p, {prev[2:0], MemRdData[7:6]} == p,
                                {prev[1:0], MemRdData[7:5]} == p, {prev[0], MemRdData[7:4]} == p};
    in_hits = 3'(in_m[0]) + 3'(in_m[1]) + 3'(in_m[2]) + 3'(in_m[3]);
    x_hits = 3'(x_m[0]) + 3'(x_m[1]) + 3'(x_m[2]) + 3'(x_m[3]);
    next = state;
    case (state)
      IDLE, DONE: next = Start ? PAT_RD : state;
      PAT_RD:     next = PAT_LD;
      PAT_LD:     next = BYTE_RD;
      BYTE_RD:    next = BYTE_CMP;
      BYTE_CMP:   next = (i < 8'(NBYTES - 1)) ? BYTE_RD : WR_CTB;
      WR_CTB:     next = WR_CTO;
      WR_CTO:     next = WR_CTS;
      WR_CTS:     next = DONE;
      default:    next = IDLE;
    endcase
    MemAddr = (state == PAT_RD) ? 8'(PAT_ADDR) :
              (state == BYTE_RD) ? i :
              (state == WR_CTB) ? 8'(RES_ADDR) :
              (state == WR_CTO) ? 8'(RES_ADDR + 1) :
              (state == WR_CTS) ? 8'(RES_ADDR + 2) : 8'd0;
    MemWrEn = (state == WR_CTB) || (state == WR_CTO) || (state == WR_CTS);
    MemWrData = (state == WR_CTB) ? ctb :
                (state == WR_CTO) ? cto :
                (state == WR_CTS) ? cts : 8'd0;
    Ack = (state == DONE);
  end
endmodule
